// File: rtl/fifo36_72_pkg.sv
// Shared constants and types for the 512 x 72 single-clock FIFO slice.
// Imported by the interface, the storage array and the top level.
package fifo36_72_pkg;

  localparam int FIFO_DEPTH = 512;
  localparam int PTR_W      = 9;
  localparam int CNT_W      = 10;
  localparam int DATA_W     = 64;
  localparam int PAR_W      = 8;

  typedef logic [PAR_W+DATA_W-1:0] fifo_word_t;

  function automatic logic [CNT_W-1:0] free_entries(input logic [CNT_W-1:0] cnt);
    return CNT_W'(FIFO_DEPTH) - cnt;
  endfunction

endpackage

// File: rtl/fifo36_72_if.sv
// Data, handshake and status bundle of the FIFO36_72-compatible slice.
// The slave side is the FIFO; the master side is whoever writes and reads it.
interface fifo36_72_if;
  import fifo36_72_pkg::*;

  logic [DATA_W-1:0] DI;
  logic [PAR_W-1:0]  DIP;
  logic              WREN;
  logic              RDEN;
  logic [DATA_W-1:0] DO;
  logic [PAR_W-1:0]  DOP;
  logic              EMPTY;
  logic              FULL;
  logic              ALMOSTEMPTY;
  logic              ALMOSTFULL;
  logic              RDERR;
  logic              WRERR;
  logic [PTR_W-1:0]  RDCOUNT;
  logic [PTR_W-1:0]  WRCOUNT;
  logic              SBITERR;
  logic              DBITERR;
  logic [7:0]        ECCPARITY;

  modport master (
    output DI, DIP, WREN, RDEN,
    input  DO, DOP, EMPTY, FULL, ALMOSTEMPTY, ALMOSTFULL, RDERR, WRERR,
    input  RDCOUNT, WRCOUNT, SBITERR, DBITERR, ECCPARITY
  );

  modport slave (
    input  DI, DIP, WREN, RDEN,
    output DO, DOP, EMPTY, FULL, ALMOSTEMPTY, ALMOSTFULL, RDERR, WRERR,
    output RDCOUNT, WRCOUNT, SBITERR, DBITERR, ECCPARITY
  );

endinterface

// File: rtl/fifo36_72_ram.sv
// Simple dual-port 512 x 72 storage with a registered, enabled read port.
// No reset on the array or the read register so it maps onto block RAM.
module fifo36_72_ram
  import fifo36_72_pkg::*;
(
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  fifo_word_t       wr_data,
  input  logic             rd_en,
  input  logic [PTR_W-1:0] rd_addr,
  output fifo_word_t       rd_data
);

  fifo_word_t mem_reg [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
    // The read register only loads on an accepted read, so it also holds DO.
    if (rd_en) begin
      rd_data <= mem_reg[rd_addr];
    end
  end

endmodule

// File: rtl/fifo36_72.sv
// Single-clock 512 x 72 standard-mode FIFO, port-compatible with FIFO36_72.
// Pointers, occupancy, registered flags and the optional output stage live here.
module fifo36_72
  import fifo36_72_pkg::*;
#(
  parameter logic [8:0] ALMOST_FULL_OFFSET      = 9'h080,
  parameter logic [8:0] ALMOST_EMPTY_OFFSET     = 9'h080,
  parameter int         DO_REG                  = 1,
  parameter             EN_SYN                  = "FALSE",
  parameter             EN_ECC_READ             = "FALSE",
  parameter             EN_ECC_WRITE            = "FALSE",
  parameter             FIRST_WORD_FALL_THROUGH = "FALSE"
) (
  input  logic        CLK,
  input  logic        RST,
  fifo36_72_if.slave  fifo
);

  if (EN_ECC_READ != "FALSE") begin : g_bad_ecc_read
    $error("fifo36_72: EN_ECC_READ must be \"FALSE\"");
  end
  if (EN_ECC_WRITE != "FALSE") begin : g_bad_ecc_write
    $error("fifo36_72: EN_ECC_WRITE must be \"FALSE\"");
  end
  if (FIRST_WORD_FALL_THROUGH != "FALSE") begin : g_bad_fwft
    $error("fifo36_72: FIRST_WORD_FALL_THROUGH must be \"FALSE\"");
  end
  // EN_SYN has no effect: the block is synchronous whatever it says.
  if (EN_SYN != "FALSE" && EN_SYN != "TRUE") begin : g_odd_en_syn
    $warning("fifo36_72: EN_SYN value not recognised, ignored");
  end

  logic [PTR_W-1:0] wp_reg;
  logic [PTR_W-1:0] rp_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             empty_reg;
  logic             full_reg;
  logic             aempty_reg;
  logic             afull_reg;
  logic             rderr_reg;
  logic             wrerr_reg;
  logic             we;
  logic             re;
  fifo_word_t       ram_q;
  fifo_word_t       dout;

  // Flags gate acceptance, so a full FIFO still reads and an empty one still writes.
  assign we = fifo.WREN && !full_reg;
  assign re = fifo.RDEN && !empty_reg;

  always_comb begin
    cnt_next = cnt_reg;
    if (we && !re) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end else if (re && !we) begin
      cnt_next = cnt_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wp_reg     <= '0;
      rp_reg     <= '0;
      cnt_reg    <= '0;
      empty_reg  <= 1'b1;
      full_reg   <= 1'b0;
      aempty_reg <= 1'b1;
      afull_reg  <= 1'b0;
      rderr_reg  <= 1'b0;
      wrerr_reg  <= 1'b0;
    end else begin
      if (we) begin
        wp_reg <= wp_reg + PTR_W'(1);
      end
      if (re) begin
        rp_reg <= rp_reg + PTR_W'(1);
      end
      cnt_reg    <= cnt_next;
      empty_reg  <= (cnt_next == '0);
      full_reg   <= (cnt_next == CNT_W'(FIFO_DEPTH));
      aempty_reg <= (cnt_next <= {1'b0, ALMOST_EMPTY_OFFSET});
      afull_reg  <= (free_entries(cnt_next) <= {1'b0, ALMOST_FULL_OFFSET});
      rderr_reg  <= fifo.RDEN && empty_reg;
      wrerr_reg  <= fifo.WREN && full_reg;
    end
  end

  fifo36_72_ram u_ram (
    .clk     (CLK),
    .wr_en   (we),
    .wr_addr (wp_reg),
    .wr_data ({fifo.DIP, fifo.DI}),
    .rd_en   (re),
    .rd_addr (rp_reg),
    .rd_data (ram_q)
  );

  if (DO_REG == 0) begin : g_lat1
    // The RAM register is unreset, so mask it until a post-reset read has landed.
    logic have_data_reg;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        have_data_reg <= 1'b0;
      end else if (re) begin
        have_data_reg <= 1'b1;
      end
    end

    assign dout = have_data_reg ? ram_q : '0;
  end else begin : g_lat2
    logic       re_d_reg;
    fifo_word_t do_reg;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        re_d_reg <= 1'b0;
        do_reg   <= '0;
      end else begin
        re_d_reg <= re;
        if (re_d_reg) begin
          do_reg <= ram_q;
        end
      end
    end

    assign dout = do_reg;
  end

  assign fifo.DO          = dout[DATA_W-1:0];
  assign fifo.DOP         = dout[PAR_W+DATA_W-1:DATA_W];
  assign fifo.EMPTY       = empty_reg;
  assign fifo.FULL        = full_reg;
  assign fifo.ALMOSTEMPTY = aempty_reg;
  assign fifo.ALMOSTFULL  = afull_reg;
  assign fifo.RDERR       = rderr_reg;
  assign fifo.WRERR       = wrerr_reg;
  assign fifo.RDCOUNT     = rp_reg;
  assign fifo.WRCOUNT     = wp_reg;
  assign fifo.SBITERR     = 1'b0;
  assign fifo.DBITERR     = 1'b0;
  assign fifo.ECCPARITY   = '0;

endmodule

// File: tb/tb_fifo36_72.sv
// Scoreboard bench for fifo36_72: one instance with DO_REG=1, one with DO_REG=0,
// both driven identically and compared against a reference FIFO model each cycle.
module tb_fifo36_72;
  import fifo36_72_pkg::*;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  fifo36_72_if bus1 ();
  fifo36_72_if bus0 ();

  fifo36_72 #(.DO_REG(1)) u_dut_reg (
    .CLK  (CLK),
    .RST  (RST),
    .fifo (bus1)
  );

  fifo36_72 #(.DO_REG(0)) u_dut_noreg (
    .CLK  (CLK),
    .RST  (RST),
    .fifo (bus0)
  );

  typedef struct {
    fifo_word_t word;
    int         due;
  } exp_t;

  exp_t       q1[$];
  exp_t       q0[$];
  fifo_word_t m_mem [FIFO_DEPTH];
  int         m_cnt;
  int         m_rp;
  int         m_wp;
  int         cyc;
  fifo_word_t exp_do1;
  fifo_word_t exp_do0;
  logic       exp_rderr;
  logic       exp_wrerr;
  int         vectors;
  int         miscompares;

  task automatic chk_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_all();
    logic [23:0] exp_flags;
    exp_flags = {m_cnt == 0, m_cnt == FIFO_DEPTH, m_cnt <= 128, (FIFO_DEPTH - m_cnt) <= 128,
                 exp_rderr, exp_wrerr, 9'(m_rp), 9'(m_wp)};
    chk_val("flags_lat2", 72'({bus1.EMPTY, bus1.FULL, bus1.ALMOSTEMPTY, bus1.ALMOSTFULL,
                              bus1.RDERR, bus1.WRERR, bus1.RDCOUNT, bus1.WRCOUNT}), 72'(exp_flags));
    chk_val("flags_lat1", 72'({bus0.EMPTY, bus0.FULL, bus0.ALMOSTEMPTY, bus0.ALMOSTFULL,
                              bus0.RDERR, bus0.WRERR, bus0.RDCOUNT, bus0.WRCOUNT}), 72'(exp_flags));
    chk_val("do_lat2", {bus1.DOP, bus1.DO}, exp_do1);
    chk_val("do_lat1", {bus0.DOP, bus0.DO}, exp_do0);
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_rp = 0;
    m_wp = 0;
    exp_rderr = 1'b0;
    exp_wrerr = 1'b0;
    exp_do1 = '0;
    exp_do0 = '0;
    q1.delete();
    q0.delete();
  endtask

  function automatic fifo_word_t rand_word();
    return {8'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  // Called at a falling edge: drive, clock once, then compare at the next falling edge.
  task automatic tick(input logic wr, input logic rd, input fifo_word_t w);
    logic we;
    logic re;
    exp_t e;
    bus1.WREN = wr;  bus0.WREN = wr;
    bus1.RDEN = rd;  bus0.RDEN = rd;
    bus1.DI = w[63:0];  bus0.DI = w[63:0];
    bus1.DIP = w[71:64]; bus0.DIP = w[71:64];
    we = wr && (m_cnt != FIFO_DEPTH);
    re = rd && (m_cnt != 0);
    exp_rderr = rd && (m_cnt == 0);
    exp_wrerr = wr && (m_cnt == FIFO_DEPTH);
    @(posedge CLK);
    cyc++;
    if (re) begin
      e.word = m_mem[m_rp];
      e.due  = cyc + 1;
      q1.push_back(e);
      e.due  = cyc;
      q0.push_back(e);
      m_rp = (m_rp + 1) % FIFO_DEPTH;
    end
    if (we) begin
      m_mem[m_wp] = w;
      m_wp = (m_wp + 1) % FIFO_DEPTH;
    end
    m_cnt = m_cnt + int'(we) - int'(re);
    @(negedge CLK);
    if (q1.size() > 0 && q1[0].due == cyc) exp_do1 = q1.pop_front().word;
    if (q0.size() > 0 && q0[0].due == cyc) exp_do0 = q0.pop_front().word;
    check_all();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    RST = 1'b1;
    bus1.WREN = 1'b0; bus0.WREN = 1'b0;
    bus1.RDEN = 1'b0; bus0.RDEN = 1'b0;
    bus1.DI = '0; bus0.DI = '0;
    bus1.DIP = '0; bus0.DIP = '0;
    model_reset();
    repeat (3) @(negedge CLK);
    check_all();
    chk_val("ecc_lat2", 72'({bus1.SBITERR, bus1.DBITERR, bus1.ECCPARITY}), 72'(0));
    chk_val("ecc_lat1", 72'({bus0.SBITERR, bus0.DBITERR, bus0.ECCPARITY}), 72'(0));
    RST = 1'b0;

    // Three tagged words out in order at latency 2 and latency 1.
    for (int i = 1; i <= 3; i++) tick(1'b1, 1'b0, {8'hA5, 64'(i)});
    repeat (3) tick(1'b0, 1'b1, '0);
    repeat (3) tick(1'b0, 1'b0, '0);

    // Empty read: RDERR pulse, pointer and DO unchanged.
    tick(1'b0, 1'b1, '0);
    tick(1'b0, 1'b0, '0);

    // Fill to full; flags are checked every cycle, covering the almost thresholds.
    repeat (FIFO_DEPTH) tick(1'b1, 1'b0, rand_word());
    tick(1'b1, 1'b0, rand_word());
    tick(1'b0, 1'b0, '0);
    tick(1'b1, 1'b1, rand_word());
    tick(1'b1, 1'b0, rand_word());

    while (m_cnt > 256) tick(1'b0, 1'b1, '0);
    repeat (40) tick(1'b1, 1'b1, rand_word());

    repeat (400) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_word());
    while (m_cnt > 0) tick(1'b0, 1'b1, '0);
    repeat (3) tick(1'b0, 1'b0, '0);
    tick(1'b1, 1'b1, rand_word());

    // Asynchronous reset with reads still in flight, checked before any clock edge.
    repeat (20) tick(1'b1, 1'b0, rand_word());
    tick(1'b0, 1'b1, '0);
    tick(1'b0, 1'b1, '0);
    bus1.RDEN = 1'b0; bus0.RDEN = 1'b0;
    #1 RST = 1'b1;
    #1 model_reset();
    check_all();
    repeat (2) @(negedge CLK);
    check_all();
    RST = 1'b0;

    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, rand_word());
    repeat (4) tick(1'b0, 1'b1, '0);
    repeat (3) tick(1'b0, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo36_72.md
Name: fifo36_72

Overview:
- Single-clock 512-deep x 72-bit block-RAM FIFO, port-compatible with the FIFO36_72 primitive.
- The 72 bits are 64 data (DI/DO) plus 8 "parity" bits (DIP/DOP), stored as plain data.
- Used as a building slice for wider FIFOs, e.g. three in parallel for a 216-bit FIFO.
- Standard (non-first-word-fall-through) read mode; the ECC ports are present for compatibility only.

Parameters:
- ALMOST_FULL_OFFSET, 9'h080: ALMOSTFULL asserts when free entries <= this value.
- ALMOST_EMPTY_OFFSET, 9'h080: ALMOSTEMPTY asserts when stored entries <= this value.
- DO_REG, 1: 0 gives read latency 1; 1 adds an output register, giving latency 2.
- EN_SYN, "FALSE": accepted for compatibility and ignored; the block is always synchronous.
- EN_ECC_READ, "FALSE": only "FALSE" is legal; any other value is an elaboration error.
- EN_ECC_WRITE, "FALSE": only "FALSE" is legal; any other value is an elaboration error.
- FIRST_WORD_FALL_THROUGH, "FALSE": only "FALSE" is legal; any other value is an elaboration error.

Ports:
- CLK  in  1  single clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- DI  in  64  write data.
- DIP  in  8  write parity data.
- WREN  in  1  write request.
- RDEN  in  1  read request.
- DO  out  64  read data.
- DOP  out  8  read parity data.
- EMPTY  out  1  FIFO holds 0 words.
- FULL  out  1  FIFO holds 512 words.
- ALMOSTEMPTY  out  1  see Behaviour.
- ALMOSTFULL  out  1  see Behaviour.
- RDERR  out  1  a read was rejected.
- WRERR  out  1  a write was rejected.
- RDCOUNT  out  9  read pointer.
- WRCOUNT  out  9  write pointer.
- SBITERR  out  1  constant 0.
- DBITERR  out  1  constant 0.
- ECCPARITY  out  8  constant 0.

Behaviour:
- State: 9-bit write pointer wp, 9-bit read pointer rp, 10-bit occupancy cnt (0..512), 512x72 storage.
- RST asserted (asynchronous): wp=rp=cnt=0; EMPTY=1, ALMOSTEMPTY=1, FULL=0, ALMOSTFULL=0; RDERR=WRERR=0; DO/DOP and the output pipeline = 0. Storage contents are not cleared.
- Reset taken mid-operation discards all contents and any read data still in flight.
- Write accepted (we) = WREN && !FULL: store {DIP,DI} at wp; wp <= wp+1, wrapping 511 -> 0.
- Read accepted (re) = RDEN && !EMPTY: rp <= rp+1, wrapping 511 -> 0.
- Read data: word at rp appears on {DOP,DO} 1 cycle after the accepted read (DO_REG=0) or 2 cycles after (DO_REG=1). DO holds its value until the next read data arrives.
- cnt <= cnt + we - re. A simultaneous accepted read and write leaves cnt unchanged.
- FIFO full (FULL=1) with RDEN and WREN together: the write is rejected and the read is accepted.
- FIFO empty (EMPTY=1) with RDEN and WREN together: the read is rejected and the write is accepted.
- All flags are registered and reflect the new cnt in the cycle after the operation:
  - EMPTY = (cnt==0).
  - FULL = (cnt==512).
  - ALMOSTEMPTY = (cnt <= ALMOST_EMPTY_OFFSET).
  - ALMOSTFULL = (512-cnt <= ALMOST_FULL_OFFSET).
- RDERR <= RDEN && EMPTY; WRERR <= WREN && FULL. Both are registered, pulse for one cycle per rejected request, and have no other side effect.
- RDCOUNT = rp; WRCOUNT = wp.

Decomposition:
- Shared package fifo36_72_pkg:
  - constants FIFO_DEPTH=512, PTR_W=9, CNT_W=10, DATA_W=64, PAR_W=8;
  - typedef fifo_word_t (72 bits).
- One natural sub-module, fifo36_72_ram: simple dual-port 512x72 synchronous-read RAM suitable for BRAM inference.
- Pointers, count, flags and the DO_REG pipeline live in the top level.

Test Plan:
- Reset -> EMPTY=1, ALMOSTEMPTY=1, FULL=0, ALMOSTFULL=0, RDCOUNT=WRCOUNT=0, RDERR=WRERR=0, DO=0.
- DO_REG=1: write 0x..01, 0x..02, 0x..03 (DIP=8'hA5), then read 3 -> DO=1, 2, 3 (DOP=8'hA5), each 2 cycles after its RDEN; EMPTY=1 after the third read. Repeat with DO_REG=0 for 1-cycle latency.
- Write 512 words -> FULL=1 the cycle after the 512th write. A 513th WREN -> WRERR pulses 1 cycle, WRCOUNT stays 0 (wrapped), contents unchanged.
- RDEN while empty -> RDERR pulses, RDCOUNT unchanged, DO unchanged.
- Default offsets: fill to 128 -> ALMOSTEMPTY=1; 129 -> ALMOSTEMPTY=0; 384 -> ALMOSTFULL=1; 383 -> ALMOSTFULL=0.
- Simultaneous RDEN+WREN at cnt=256 -> cnt stays 256 and data order is preserved. RST asserted mid-stream -> flags return to reset values asynchronously, with no clock edge required.
